rrp_burst_arbiter: RTL and testbench
====================================

Name: rrp_burst_arbiter

Overview:
Parametrised successor to the current 7-input round-robin FIFO arbiter used in the readout core. It merges N first-word-fall-through source FIFOs (FE data, TLU, timestamp channels) into one 32-bit output stream. Over the current arbiter it adds:
- a per-channel enable mask
- a bounded burst length per grant
- HOLD-based grant locking
- a registered output stage that carries the source channel ID alongside each word

Parameters:
WIDTH, 8, number of source channels (2..32).
DATA_WIDTH, 32, word width.
MAX_BURST, 4, maximum words per grant when HOLD is low (1..255).
ID_WIDTH, 5, width of ID_OUT; must satisfy 2**ID_WIDTH >= WIDTH.

Ports:
CLK  in  1  single clock for all logic.
nRST  in  1  asynchronous, active-low reset.
CH_EN  in  WIDTH  per-channel enable; 0 masks the channel from arbitration.
WRITE_REQ  in  WIDTH  per-channel data available (~FIFO_EMPTY); DATA_IN is valid while this is high.
HOLD_REQ  in  WIDTH  while granted, keeps the grant past MAX_BURST and across empty cycles.
DATA_IN  in  WIDTH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
READ_GRANT  out  WIDTH  one-hot FIFO read strobe (combinational).
READY_OUT  in  1  downstream can accept; sink must tolerate one word after deassert.
WRITE_OUT  out  1  registered output valid strobe.
DATA_OUT  out  DATA_WIDTH  registered output word.
ID_OUT  out  ID_WIDTH  channel index of DATA_OUT.
BUSY  out  1  high in GRANT state.

Behaviour:
- Reset (nRST low, async):
  - state = IDLE, rr_ptr = 0, burst_cnt = 0, grant_id = 0.
  - WRITE_OUT = 0, DATA_OUT = 0, ID_OUT = 0, BUSY = 0, READ_GRANT = 0.
  - Deassertion is synchronised internally by a 2-flop release.
- Eligibility: req_eff = WRITE_REQ & CH_EN.
- States: IDLE, GRANT.
- IDLE:
  - If req_eff != 0, pick the first set bit searching from rr_ptr upward, wrapping modulo WIDTH.
  - Register grant_id, clear burst_cnt, go to GRANT next cycle.
  - No READ_GRANT is issued in IDLE, so a channel switch costs exactly one cycle.
- GRANT, with g = grant_id:
  - READ_GRANT[g] = WRITE_REQ[g] & CH_EN[g] & READY_OUT. All other bits are 0.
  - On each read:
    - burst_cnt increments.
    - DATA_OUT <= DATA_IN[g], ID_OUT <= g, WRITE_OUT <= 1 on the next edge, so latency is 1 cycle.
    - Otherwise WRITE_OUT <= 0 and DATA_OUT/ID_OUT hold their values.
  - Release to IDLE (rr_ptr <= (g+1) mod WIDTH) when any of these is true:
    - CH_EN[g] = 0. This releases even if HOLD_REQ[g] = 1, with no read that cycle.
    - HOLD_REQ[g] = 0 and burst_cnt reaches MAX_BURST. This includes the cycle the MAX_BURST-th read occurs.
    - HOLD_REQ[g] = 0 and WRITE_REQ[g] = 0.
  - HOLD_REQ[g] = 1 with WRITE_REQ[g] = 0: stay in GRANT, issue no reads, and block other channels.
  - burst_cnt saturates at 255 while held.
- READY_OUT low: no reads occur, burst_cnt is frozen, and the grant is kept. A low READY_OUT alone never causes a release.
- Channel index WIDTH-1 wraps to 0 for rr_ptr.
- Simultaneous requests in IDLE resolve strictly by rotating priority, which guarantees no starvation. A channel waits at most (WIDTH-1)*(MAX_BURST+1) cycles when no HOLD is used and READY_OUT stays high.
- CH_EN changes take effect the same cycle for both selection and release.
- BUSY = (state == GRANT).

Test Plan:
1. Single channel: WIDTH=8, MAX_BURST=4, ch3 has 10 words, READY=1.
   - Required: bursts of 4, 4, 2 with 1 idle cycle between them.
   - ID_OUT = 3 throughout; WRITE_OUT one cycle after each READ_GRANT[3]; data order preserved.
2. Fairness: ch0, ch5, ch7 always requesting, rr_ptr=0.
   - Required: grant order 0, 5, 7, 0, 5, ...; each burst exactly 4 words.
3. HOLD lock: ch2 has HOLD=1 and 9 words, then empties for 5 cycles, then gets 1 more word; ch4 requesting throughout.
   - Required: ch2 gets all 10 words with no ch4 grant in between.
   - ch4 is granted 2 cycles after HOLD drops.
4. Backpressure: READY_OUT low for 6 cycles mid-burst after word 2.
   - Required: no READ_GRANT during those cycles; at most 1 WRITE_OUT after the deassert.
   - Burst resumes and ends at exactly 4 words.
5. Mask: CH_EN[1] dropped while ch1 is granted with HOLD=1.
   - Required: READ_GRANT[1]=0 that cycle; state returns to IDLE next edge.
   - ch1 is ignored while CH_EN[1] stays low, even with WRITE_REQ[1]=1.
6. Async reset mid-burst: nRST low between clock edges.
   - Required: WRITE_OUT, READ_GRANT and BUSY go to 0 immediately.
   - After release, arbitration restarts from ch0.

Source files
------------

// File: rtl/rrp_burst_arbiter_if.sv
// Bus bundle for the round-robin burst arbiter: source FIFO side
// (requests, hold, data, read strobes) plus the registered output stream.
interface rrp_burst_arbiter_if #(
   parameter int WIDTH      = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 5
);
   logic [WIDTH-1:0]            CH_EN;
   logic [WIDTH-1:0]            WRITE_REQ;
   logic [WIDTH-1:0]            HOLD_REQ;
   logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
   logic [WIDTH-1:0]            READ_GRANT;
   logic                        READY_OUT;
   logic                        WRITE_OUT;
   logic [DATA_WIDTH-1:0]       DATA_OUT;
   logic [ID_WIDTH-1:0]         ID_OUT;
   logic                        BUSY;

   // Arbiter side: consumes requests, drives read strobes and the output stream.
   modport master (
      input  CH_EN, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
      output READ_GRANT, WRITE_OUT, DATA_OUT, ID_OUT, BUSY
   );

   // Environment side: source FIFOs and downstream sink.
   modport slave (
      output CH_EN, WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
      input  READ_GRANT, WRITE_OUT, DATA_OUT, ID_OUT, BUSY
   );
endinterface

// File: rtl/rrp_burst_arbiter.sv
// Round-robin arbiter merging WIDTH first-word-fall-through FIFOs into one
// registered output stream. Grants are bounded to MAX_BURST words unless the
// granted channel asserts HOLD_REQ; each output word carries its channel ID.
module rrp_burst_arbiter #(
   parameter int WIDTH      = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = 5
) (
   input  logic                  CLK,
   input  logic                  nRST,
   rrp_burst_arbiter_if.master   bus
);

   localparam int                IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [7:0]        BURST_LIM = 8'(MAX_BURST);
   localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(WIDTH - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                 state_q;
   logic [IDX_W-1:0]       grant_id_q;
   logic [IDX_W-1:0]       rr_ptr_q;
   logic [7:0]             burst_cnt_q;
   logic                   write_out_q;
   logic [DATA_WIDTH-1:0]  data_out_q;
   logic [ID_WIDTH-1:0]    id_out_q;
   logic [1:0]             rst_sync_q;
   logic                   rst_n_int;

   logic [WIDTH-1:0]       req_eff;
   logic [DATA_WIDTH-1:0]  ch_data [WIDTH];
   logic                   g_en;
   logic                   g_req;
   logic                   g_hold;
   logic                   rd_en;
   logic                   release_d;
   logic [7:0]             burst_cnt_d;
   logic [IDX_W-1:0]       rr_ptr_d;
   logic [IDX_W-1:0]       pick_d;
   logic [WIDTH-1:0]       grant_vec;

   // Burst counter increment that sticks at 255 during long HOLD grants.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // First set request at or above ptr, wrapping past WIDTH-1 back to 0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [WIDTH-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] sel;
      logic             found;
      int               j;
      sel   = ptr;
      found = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         j = int'(ptr) + i;
         if (j >= WIDTH) j = j - WIDTH;
         if (!found && req[IDX_W'(j)]) begin
            found = 1'b1;
            sel   = IDX_W'(j);
         end
      end
      return sel;
   endfunction

   // Reset asserts immediately but releases only after two clean clock edges.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) rst_sync_q <= 2'b00;
      else       rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n_int = rst_sync_q[1];

   // Split the flat data bus into per-channel words.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         ch_data[i] = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Read qualification, burst accounting and release decision for the granted channel.
   always_comb begin
      req_eff     = bus.WRITE_REQ & bus.CH_EN;
      g_en        = bus.CH_EN[grant_id_q];
      g_req       = bus.WRITE_REQ[grant_id_q];
      g_hold      = bus.HOLD_REQ[grant_id_q];
      rd_en       = (state_q == GRANT) && g_req && g_en && bus.READY_OUT;
      burst_cnt_d = rd_en ? sat_inc(burst_cnt_q) : burst_cnt_q;
      // Disabling the channel wins over HOLD; otherwise an unheld grant ends
      // on its MAX_BURST-th read or as soon as its FIFO runs dry.
      release_d   = (state_q == GRANT) &&
                    (!g_en ||
                     (!g_hold && (burst_cnt_d >= BURST_LIM)) ||
                     (!g_hold && !g_req));
      rr_ptr_d    = (grant_id_q == LAST_CH) ? '0 : grant_id_q + 1'b1;
      pick_d      = rr_pick(req_eff, rr_ptr_q);
   end

   // One-hot FIFO read strobe, only ever for the granted channel.
   always_comb begin
      grant_vec = '0;
      if (rd_en) grant_vec[grant_id_q] = 1'b1;
   end

   // Arbitration FSM with the registered output word, ID and valid.
   always_ff @(posedge CLK or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q     <= IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         write_out_q <= 1'b0;
         data_out_q  <= '0;
         id_out_q    <= '0;
      end else begin
         write_out_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // No read here: a channel switch always costs this one cycle.
               if (|req_eff) begin
                  grant_id_q  <= pick_d;
                  burst_cnt_q <= '0;
                  state_q     <= GRANT;
               end
            end
            GRANT: begin
               burst_cnt_q <= burst_cnt_d;
               if (rd_en) begin
                  write_out_q <= 1'b1;
                  data_out_q  <= ch_data[grant_id_q];
                  id_out_q    <= ID_WIDTH'(grant_id_q);
               end
               if (release_d) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= rr_ptr_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.READ_GRANT = grant_vec;
   assign bus.WRITE_OUT  = write_out_q;
   assign bus.DATA_OUT   = data_out_q;
   assign bus.ID_OUT     = id_out_q;
   assign bus.BUSY       = (state_q == GRANT);

   // Structural invariants of the read strobe.
   a_grant_onehot: assert property (@(posedge CLK) disable iff (!rst_n_int)
      $onehot0(bus.READ_GRANT));
   a_no_read_stalled: assert property (@(posedge CLK) disable iff (!rst_n_int)
      !bus.READY_OUT |-> (bus.READ_GRANT == '0));
   a_no_read_idle: assert property (@(posedge CLK) disable iff (!rst_n_int)
      (state_q == IDLE) |-> (bus.READ_GRANT == '0));

endmodule

// File: tb/tb_rrp_burst_arbiter.sv
// Directed bench for rrp_burst_arbiter: behavioural source FIFOs feed the DUT,
// every cycle is logged, and the logs are compared with hand-derived timelines.
module tb_rrp_burst_arbiter;

   localparam int WIDTH      = 8;
   localparam int DATA_WIDTH = 32;
   localparam int MAX_BURST  = 4;
   localparam int ID_WIDTH   = 5;
   localparam int LOGN       = 64;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;

   always #5 CLK = ~CLK;

   rrp_burst_arbiter_if #(.WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

   rrp_burst_arbiter #(
      .WIDTH(WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_WIDTH(ID_WIDTH)
   ) u_dut (
      .CLK (CLK),
      .nRST(nRST),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] fmem [WIDTH][64];
   int          wp [WIDTH];
   int          rp [WIDTH];

   logic [7:0]  lg_rg   [LOGN];
   logic        lg_wo   [LOGN];
   logic [31:0] lg_do   [LOGN];
   logic [4:0]  lg_id   [LOGN];
   logic        lg_busy [LOGN];
   int          cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int oh2i(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic push(input int ch, input logic [31:0] w);
      fmem[ch][wp[ch]] = w;
      wp[ch]++;
   endtask

   task automatic drive_inputs();
      for (int ch = 0; ch < WIDTH; ch++) begin
         bus.WRITE_REQ[ch] = (wp[ch] != rp[ch]);
         bus.DATA_IN[ch*DATA_WIDTH +: DATA_WIDTH] = (wp[ch] != rp[ch]) ? fmem[ch][rp[ch]] : 32'h0;
      end
   endtask

   // One clock: present FIFO heads, log outputs at the falling edge, pop on the rising edge.
   task automatic tick();
      drive_inputs();
      @(negedge CLK);
      lg_rg[cyc]   = bus.READ_GRANT;
      lg_wo[cyc]   = bus.WRITE_OUT;
      lg_do[cyc]   = bus.DATA_OUT;
      lg_id[cyc]   = bus.ID_OUT;
      lg_busy[cyc] = bus.BUSY;
      @(posedge CLK);
      #1;
      for (int ch = 0; ch < WIDTH; ch++) if (lg_rg[cyc][ch]) rp[ch]++;
      cyc++;
   endtask

   task automatic do_reset();
      for (int ch = 0; ch < WIDTH; ch++) begin
         wp[ch] = 0;
         rp[ch] = 0;
      end
      bus.CH_EN     = '1;
      bus.HOLD_REQ  = '0;
      bus.READY_OUT = 1'b1;
      drive_inputs();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      cyc = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] m, m2, m3;
      int          k, cnt, first;
      int          nb;
      logic [7:0]  prev;
      int          ch_seq  [8];
      int          len_seq [8];
      int          exp_ch  [5] = '{0, 5, 7, 0, 5};
      logic [7:0]  first_rg;

      // Reset state with every channel requesting.
      for (int ch = 0; ch < WIDTH; ch++) begin
         wp[ch] = 0;
         rp[ch] = 0;
         push(ch, 32'hA000_0000 + ch);
      end
      bus.CH_EN     = '1;
      bus.HOLD_REQ  = '0;
      bus.READY_OUT = 1'b1;
      drive_inputs();
      #1 nRST = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("rst_read_grant", 32'(bus.READ_GRANT), 32'h0);
      chk("rst_write_out",  32'(bus.WRITE_OUT),  32'h0);
      chk("rst_busy",       32'(bus.BUSY),       32'h0);
      chk("rst_data_out",   bus.DATA_OUT,        32'h0);
      chk("rst_id_out",     32'(bus.ID_OUT),     32'h0);

      // 1: ch3 alone with 10 words -> bursts 4,4,2 separated by one idle cycle.
      do_reset();
      for (int i = 0; i < 10; i++) push(3, 32'h3000_0000 + i);
      for (int c = 0; c < 16; c++) tick();
      m = '0; m2 = '0; m3 = '0; cnt = 0;
      for (int c = 0; c < 16; c++) begin
         m[c]  = lg_rg[c][3];
         m2[c] = lg_wo[c];
         m3[c] = lg_busy[c];
         if ((lg_rg[c] & 8'hF7) != 8'h00) cnt++;
      end
      chk("t1_grant_mask", m,  32'h0000_1BDE);
      chk("t1_wout_mask",  m2, 32'h0000_37BC);
      chk("t1_busy_mask",  m3, 32'h0000_3BDE);
      chk("t1_other_grants", cnt, 0);
      k = 0;
      for (int c = 0; c < 16; c++) begin
         if (lg_wo[c]) begin
            chk("t1_data", lg_do[c], 32'h3000_0000 + k);
            chk("t1_id", 32'(lg_id[c]), 32'd3);
            k++;
         end
      end
      chk("t1_nwords", k, 10);

      // 2: ch0, ch5, ch7 always requesting -> order 0,5,7,0,5, four words each.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         push(0, 32'h0000_0100 + i);
         push(5, 32'h0000_0500 + i);
         push(7, 32'h0000_0700 + i);
      end
      for (int c = 0; c < 26; c++) tick();
      nb = 0;
      prev = 8'h00;
      for (int i = 0; i < 8; i++) begin
         ch_seq[i]  = -1;
         len_seq[i] = 0;
      end
      for (int c = 0; c < 26; c++) begin
         if (lg_rg[c] != 8'h00) begin
            if (lg_rg[c] != prev) begin
               if (nb < 8) begin
                  ch_seq[nb]  = oh2i(lg_rg[c]);
                  len_seq[nb] = 1;
               end
               nb++;
            end else if (nb > 0 && nb <= 8) begin
               len_seq[nb-1]++;
            end
         end
         prev = lg_rg[c];
      end
      chk("t2_nbursts", nb, 5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_burst_ch",  ch_seq[i],  exp_ch[i]);
         chk("t2_burst_len", len_seq[i], MAX_BURST);
      end

      // 3: ch2 holds through 9 words, 5 empty cycles and one late word; ch4 waits.
      do_reset();
      for (int i = 0; i < 9; i++) push(2, 32'h2000_0000 + i);
      for (int i = 0; i < 8; i++) push(4, 32'h4000_0000 + i);
      bus.HOLD_REQ[2] = 1'b1;
      for (int c = 0; c < 25; c++) begin
         if (c == 15) push(2, 32'h2000_0009);
         if (c == 16) bus.HOLD_REQ[2] = 1'b0;
         tick();
      end
      cnt = 0; first = -1; m = '0; m2 = 32'h1;
      for (int c = 0; c < 25; c++) begin
         if (lg_rg[c][2]) cnt++;
         if (lg_rg[c][4] && first < 0) first = c;
         if (lg_wo[c] && lg_id[c] == 5'd2) m = lg_do[c];
      end
      for (int c = 10; c < 15; c++) if (lg_rg[c] != 8'h00) m2 = 32'h0;
      chk("t3_ch2_reads", cnt, 10);
      chk("t3_ch2_last_word", m, 32'h2000_0009);
      chk("t3_gap_no_reads", m2, 32'h1);
      chk("t3_gap_busy", 32'(lg_busy[12]), 32'h1);
      chk("t3_release_busy", 32'(lg_busy[17]), 32'h0);
      chk("t3_ch4_first_grant", first, 18);

      // 4: READY_OUT low for 6 cycles after the second word of a burst.
      do_reset();
      for (int i = 0; i < 10; i++) push(1, 32'h1000_0000 + i);
      for (int c = 0; c < 12; c++) begin
         if (c == 3) bus.READY_OUT = 1'b0;
         if (c == 9) bus.READY_OUT = 1'b1;
         tick();
      end
      m = '0; m2 = '0; m3 = '0; cnt = 0; k = 0;
      for (int c = 0; c < 12; c++) begin
         m[c]  = lg_rg[c][1];
         m2[c] = lg_wo[c];
         m3[c] = lg_busy[c];
      end
      for (int c = 3; c < 9; c++) begin
         if (lg_rg[c] != 8'h00) cnt++;
         if (lg_wo[c]) k++;
      end
      chk("t4_stall_grants", cnt, 0);
      chk("t4_stall_wouts", k, 1);
      chk("t4_grant_mask", m,  32'h0000_0606);
      chk("t4_wout_mask",  m2, 32'h0000_0C0C);
      chk("t4_busy_mask",  m3, 32'h0000_07FE);
      chk("t4_hold_data", lg_do[8],  32'h1000_0001);
      chk("t4_last_data", lg_do[11], 32'h1000_0003);

      // 5: CH_EN[1] dropped while ch1 is granted with HOLD; ch3 also requesting.
      do_reset();
      for (int i = 0; i < 8; i++)  push(1, 32'h1100_0000 + i);
      for (int i = 0; i < 12; i++) push(3, 32'h3300_0000 + i);
      bus.HOLD_REQ[1] = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (c == 3) bus.CH_EN[1] = 1'b0;
         tick();
      end
      cnt = 0;
      for (int c = 3; c < 14; c++) if (lg_rg[c][1]) cnt++;
      chk("t5_grant_c2", 32'(lg_rg[2]), 32'h02);
      chk("t5_grant_mask_cycle", 32'(lg_rg[3]), 32'h00);
      chk("t5_busy_mask_cycle", 32'(lg_busy[3]), 32'h1);
      chk("t5_idle_next", 32'(lg_busy[4]), 32'h0);
      chk("t5_ch1_ignored", cnt, 0);
      chk("t5_ch3_first", 32'(lg_rg[5]), 32'h08);
      chk("t5_ch3_again", 32'(lg_rg[10]), 32'h08);
      bus.HOLD_REQ[1] = 1'b0;
      bus.CH_EN[1]    = 1'b1;

      // 6: asynchronous reset in the middle of a ch2 burst.
      do_reset();
      for (int i = 0; i < 8; i++) push(2, 32'h2200_0000 + i);
      for (int c = 0; c < 3; c++) tick();
      for (int i = 0; i < 4; i++) begin
         push(1, 32'h1200_0000 + i);
         push(3, 32'h3200_0000 + i);
      end
      drive_inputs();
      #1;
      chk("t6_pre_grant", 32'(bus.READ_GRANT), 32'h04);
      chk("t6_pre_wout",  32'(bus.WRITE_OUT),  32'h1);
      chk("t6_pre_busy",  32'(bus.BUSY),       32'h1);
      nRST = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(bus.READ_GRANT), 32'h00);
      chk("t6_rst_wout",  32'(bus.WRITE_OUT),  32'h0);
      chk("t6_rst_busy",  32'(bus.BUSY),       32'h0);
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      cyc = 0;
      first_rg = 8'h00;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (first_rg == 8'h00 && lg_rg[cyc-1] != 8'h00) first_rg = lg_rg[cyc-1];
      end
      chk("t6_restart_from_ch0", 32'(first_rg), 32'h02);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
